// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums a programmed number of unsigned products
// from the upstream multiplier into a saturating total with a sticky overflow flag.
module product_accumulator #(
    parameter int M     = 3,
    parameter int N     = 2,
    parameter int ACC_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [M+N-1:0]   s_prod,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_sum,
    output logic             m_ovf,
    output logic             busy
);

    localparam int PW = M + N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_xfer;
    logic             w_last;
    logic [ACC_W:0]   w_sum;

    // One spare bit above the accumulator catches the carry that signals saturation.
    assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - PW){1'b0}}, s_prod};
    assign w_xfer = s_ready && s_valid;
    assign w_last = w_xfer && (r_cnt == LEN_W'(1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first so no path through the case leaves a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only, so no input-to-output path exists.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b0;
        case (r_state)
            ACC: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                m_valid = 1'b1;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_acc <= '0;
            r_cnt <= len;
            r_ovf <= 1'b0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt - LEN_W'(1);
            if (w_sum[ACC_W]) begin
                r_acc <= '1;
                r_ovf <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end

    assign m_sum = r_acc;
    assign m_ovf = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomised scoreboard bench for product_accumulator (M=3, N=2, ACC_W=8, LEN_W=8):
// stimulus pushes the expected saturated total per job, a monitor pops it on each result handshake.
module tb_product_accumulator;

    localparam int M     = 3;
    localparam int N     = 2;
    localparam int ACC_W = 8;
    localparam int LEN_W = 8;
    localparam int SAT   = (1 << ACC_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             s_valid;
    logic             s_ready;
    logic [M+N-1:0]   s_prod;
    logic             m_valid;
    logic             m_ready;
    logic [ACC_W-1:0] m_sum;
    logic             m_ovf;
    logic             busy;

    typedef struct {
        int sum;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   stim_q[$];
    int   n_checks;
    int   n_errors;

    product_accumulator #(
        .M    (M),
        .N    (N),
        .ACC_W(ACC_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .len    (len),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_prod (s_prod),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_sum  (m_sum),
        .m_ovf  (m_ovf),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the oldest expected job on every result handshake and checks hold-stability under backpressure.
    logic             prev_stall;
    logic [ACC_W-1:0] prev_sum;
    logic             prev_ovf;

    initial begin
        prev_stall = 1'b0;
        prev_sum   = '0;
        prev_ovf   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_m_valid", int'(m_valid), 1);
                    check("hold_m_sum", int'(m_sum), int'(prev_sum));
                    check("hold_m_ovf", int'(m_ovf), int'(prev_ovf));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_result: got sum %0d with no job pending", m_sum);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("result_sum", int'(m_sum), e.sum);
                        check("result_ovf", int'(m_ovf), int'(e.ovf));
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_sum   = m_sum;
                prev_ovf   = m_ovf;
            end
        end
    end

    // Runs one job over the products in stim_q; the reference result is the plain total clipped to ACC_W bits.
    task automatic run_job(input int n, input int gap, input int hold, input bit busy_start);
        int   total;
        exp_t e;
        total = 0;
        for (int i = 0; i < n; i++) total += stim_q[i];
        e.sum = (total > SAT) ? SAT : total;
        e.ovf = (total > SAT);
        exp_q.push_back(e);

        m_ready = (hold == 0);
        start   = 1'b1;
        len     = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
        if (n == 0) begin
            check("zero_len_m_valid", int'(m_valid), 1);
            check("zero_len_s_ready", int'(s_ready), 0);
        end else begin
            check("start_s_ready", int'(s_ready), 1);
            check("start_busy", int'(busy), 1);
        end

        for (int i = 0; i < n; i++) begin
            int budget;
            s_valid = 1'b1;
            s_prod  = (M+N)'(stim_q[i]);
            budget  = 0;
            while (!s_ready && budget < 100) begin
                tick();
                budget++;
            end
            if (!s_ready) check("s_ready_timeout", 0, 1);
            tick();
            s_valid = 1'b0;
            s_prod  = (M+N)'($urandom);
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (busy_start && g == 0) begin
                        start = 1'b1;
                        len   = LEN_W'(9);
                    end
                    tick();
                    start = 1'b0;
                end
            end
        end

        if (n != 0) begin
            check("latency_m_valid", int'(m_valid), 1);
            check("latency_s_ready", int'(s_ready), 0);
        end
        for (int h = 0; h < hold; h++) tick();
        m_ready = 1'b1;
        tick();
        check("post_result_m_valid", int'(m_valid), 0);
        check("post_result_busy", int'(busy), 0);
        m_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        s_valid  = 1'b0;
        s_prod   = '0;
        m_ready  = 1'b0;
        #1;
        check("reset_s_ready", int'(s_ready), 0);
        check("reset_m_valid", int'(m_valid), 0);
        check("reset_busy", int'(busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic sum.
        stim_q = '{21, 6, 0};
        run_job(3, 0, 0, 1'b0);

        // Saturation, then a clean job proving ovf is cleared.
        stim_q = {};
        for (int i = 0; i < 13; i++) stim_q.push_back(21);
        run_job(13, 0, 0, 1'b0);
        stim_q = '{5};
        run_job(1, 0, 0, 1'b0);

        // Zero length.
        stim_q = {};
        run_job(0, 0, 0, 1'b0);

        // Gaps between products plus five cycles of backpressure.
        stim_q = '{1, 2, 3, 4};
        run_job(4, 2, 5, 1'b0);

        // Reset in the middle of a job.
        start = 1'b1;
        len   = LEN_W'(4);
        tick();
        start   = 1'b0;
        s_valid = 1'b1;
        s_prod  = (M+N)'(5);
        tick();
        s_prod = (M+N)'(6);
        tick();
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_s_ready", int'(s_ready), 0);
        check("midreset_m_valid", int'(m_valid), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_m_sum", int'(m_sum), 0);
        check("midreset_m_ovf", int'(m_ovf), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        stim_q = '{7};
        run_job(1, 0, 0, 1'b0);

        // Start pulsed while busy must be ignored.
        stim_q = '{3, 3};
        run_job(2, 1, 0, 1'b1);

        // Random jobs.
        for (int j = 0; j < 16; j++) begin
            int n;
            n = int'($urandom_range(0, 20));
            stim_q = {};
            for (int i = 0; i < n; i++) stim_q.push_back(int'($urandom_range(0, 31)));
            run_job(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
        end

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
